// File: rtl/usr_pkg.sv
// usr_pkg: shared op codes, FSM states and default width for universal_shift_reg
package usr_pkg;
  localparam int USR_WIDTH = 8;
  typedef enum logic [2:0] {
    OP_HOLD = 3'd0,
    OP_LOAD = 3'd1,
    OP_SHR  = 3'd2,
    OP_SHL  = 3'd3,
    OP_ASR  = 3'd4,
    OP_ROR  = 3'd5,
    OP_ROL  = 3'd6,
    OP_RSVD = 3'd7
  } op_e;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;
endpackage

// File: rtl/usr_bit_cell.sv
// usr_bit_cell: one register bit with load/shift next-state mux.
// Ports: clk, rst (sync, active-high), load/shift/left controls, d (parallel bit),
// r_nb (value arriving on a right shift), l_nb (value arriving on a left shift), q (flop output).
module usr_bit_cell (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic shift,
  input  logic left,
  input  logic d,
  input  logic r_nb,
  input  logic l_nb,
  output logic q
);
  logic q_q, q_d;
  always_comb q_d = load ? d : shift ? (left ? l_nb : r_nb) : q_q;
  always_ff @(posedge clk)
    if (rst) q_q <= 1'b0;
    else     q_q <= q_d;
  assign q = q_q;
endmodule

// File: rtl/universal_shift_reg.sv
// universal_shift_reg: multi-cycle universal shift register (load/shift/arith/rotate) with IDLE/SHIFT/DONE FSM.
// Ports: clk, rst (sync, active-high), start/op/amt request, d parallel data, si_r/si_l serial inputs,
// q register, busy (in SHIFT), done (one-cycle pulse), so_r = q[0], so_l = q[WIDTH-1].
// Define USR_ROTATE_EN to build ROR/ROL; otherwise those op codes behave as HOLD.
module universal_shift_reg
  import usr_pkg::*;
#(
  parameter int WIDTH = USR_WIDTH,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [CNT_W-1:0] amt,
  input  logic [WIDTH-1:0] d,
  input  logic             si_r,
  input  logic             si_l,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             so_r,
  output logic             so_l
);
  state_e           state_q, state_d;
  op_e              op_q, op_d, op_in;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load, step, is_shift, left, msb_in, lsb_in;
  logic [WIDTH-1:0] r_nb, l_nb;
  assign op_in = op_e'(op);
`ifdef USR_ROTATE_EN
  assign is_shift = op_in inside {OP_SHR, OP_SHL, OP_ASR, OP_ROR, OP_ROL};
  assign left     = op_q == OP_SHL || op_q == OP_ROL;
  assign msb_in   = op_q == OP_SHR ? si_r : op_q == OP_ASR ? q[WIDTH-1] : q[0];
  assign lsb_in   = op_q == OP_ROL ? q[WIDTH-1] : si_l;
`else
  assign is_shift = op_in inside {OP_SHR, OP_SHL, OP_ASR};
  assign left     = op_q == OP_SHL;
  assign msb_in   = op_q == OP_SHR ? si_r : q[WIDTH-1];
  assign lsb_in   = si_l;
`endif
  assign r_nb = {msb_in, q[WIDTH-1:1]};
  assign l_nb = {q[WIDTH-2:0], lsb_in};
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      S_IDLE: if (start) begin
        op_d    = op_in;
        cnt_d   = amt;
        load    = op_in == OP_LOAD;
        state_d = (is_shift && amt != '0) ? S_SHIFT : S_DONE;
      end
      S_SHIFT: begin
        step    = 1'b1;
        cnt_d   = cnt_q - CNT_W'(1);
        state_d = cnt_q == CNT_W'(1) ? S_DONE : S_SHIFT;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_HOLD;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    usr_bit_cell u_cell (
      .clk  (clk),
      .rst  (rst),
      .load (load),
      .shift(step),
      .left (left),
      .d    (d[i]),
      .r_nb (r_nb[i]),
      .l_nb (l_nb[i]),
      .q    (q[i])
    );
  end
  assign busy = state_q == S_SHIFT;
  assign done = state_q == S_DONE;
  assign so_r = q[0];
  assign so_l = q[WIDTH-1];
endmodule

// File: tb/tb_universal_shift_reg.sv
// tb_universal_shift_reg: randomized self-checking bench against a behavioural shift model
module tb_universal_shift_reg;
  logic       clk = 0, rst = 1, start = 0, si_r = 0, si_l = 0;
  logic [2:0] op = 0;
  logic [3:0] amt = 0;
  logic [7:0] d = 0, q, exp_q = 0;
  logic       busy, done, so_r, so_l;
  int         n_chk = 0, n_fail = 0;

  universal_shift_reg dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .amt(amt), .d(d),
    .si_r(si_r), .si_l(si_l), .q(q), .busy(busy), .done(done), .so_r(so_r), .so_l(so_l)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit shifts(input logic [2:0] o);
`ifdef USR_ROTATE_EN
    return o >= 2 && o <= 6;
`else
    return o >= 2 && o <= 4;
`endif
  endfunction

  function automatic logic [7:0] step(input logic [2:0] o, input logic [7:0] v, input logic sr, input logic sl);
    case (o)
      3'd2:    return (v >> 1) | (sr ? 8'h80 : 8'h00);
      3'd3:    return (v << 1) | (sl ? 8'h01 : 8'h00);
      3'd4:    return 8'($signed(v) >>> 1);
      3'd5:    return (v >> 1) | (v << 7);
      3'd6:    return (v << 1) | (v >> 7);
      default: return v;
    endcase
  endfunction

  task automatic do_op(input logic [2:0] o, input logic [3:0] a, input logic [7:0] dv,
                       input logic sr, input logic sl, input bit rnd);
    int steps;
    @(negedge clk);
    start = 1; op = o; amt = a; d = dv; si_r = sr; si_l = sl;
    @(posedge clk);
    if (o == 3'd1) exp_q = dv;
    #1;
    start = 0;
    steps = (shifts(o) && a != 0) ? int'(a) : 0;
    for (int k = 0; k < steps; k++) begin
      check("busy", busy, 1);
      check("done_early", done, 0);
      @(negedge clk);
      if (rnd) begin si_r = 1'($urandom); si_l = 1'($urandom); end
      start = 1'($urandom); op = 3'd1; d = 8'($urandom);
      @(posedge clk);
      exp_q = step(o, exp_q, si_r, si_l);
      #1;
    end
    check("busy_end", busy, 0);
    check("done", done, 1);
    check("q", q, exp_q);
    check("so_r", so_r, exp_q[0]);
    check("so_l", so_l, exp_q[7]);
    @(negedge clk);
    start = 0;
    @(posedge clk);
    #1;
    check("done_len", done, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    start = 1; op = 3'd1; d = 8'hFF;
    @(posedge clk);
    #1;
    check("rst_q", q, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(negedge clk);
    rst = 0; start = 0;
    do_op(3'd1, 4'd0, 8'hA5, 0, 0, 0);
    do_op(3'd2, 4'd3, 8'h00, 1, 0, 0);
    check("shr_f4", q, 8'hF4);
    do_op(3'd1, 4'd0, 8'h81, 0, 0, 0);
    do_op(3'd4, 4'd2, 8'h00, 0, 0, 0);
    check("asr_e0", q, 8'hE0);
    do_op(3'd1, 4'd0, 8'h81, 0, 0, 0);
    do_op(3'd3, 4'd1, 8'h00, 0, 0, 0);
    check("shl_02", q, 8'h02);
    do_op(3'd1, 4'd0, 8'h81, 0, 0, 0);
    do_op(3'd6, 4'd9, 8'h00, 0, 0, 0);
`ifdef USR_ROTATE_EN
    check("rol_03", q, 8'h03);
`else
    check("rol_hold", q, 8'h81);
`endif
    do_op(3'd7, 4'd5, 8'h3C, 0, 0, 0);
    do_op(3'd2, 4'd0, 8'h3C, 1, 1, 0);
    do_op(3'd3, 4'd15, 8'h00, 1, 1, 0);
    for (int i = 0; i < 150; i++)
      do_op(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 8'($urandom), 1'($urandom), 1'($urandom), 1);
    do_op(3'd1, 4'd0, 8'h5A, 0, 0, 0);
    @(negedge clk);
    start = 1; op = 3'd2; amt = 4'd10;
    @(posedge clk);
    #1;
    start = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
    exp_q = 0;
    check("abort_q", q, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    @(negedge clk);
    rst = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check("abort_nodone", done, 0);
      check("abort_idle", busy, 0);
    end
    do_op(3'd5, 4'd3, 8'h00, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/universal_shift_reg.md
UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 8, register width in bits (legal range 2..64).
REQ-002 SHALL have parameter CNT_W, default 4, width of the shift-amount input.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1  operation request, sampled only in IDLE.
REQ-006 SHALL have port op  input  3  operation code (see REQ-011).
REQ-007 SHALL have port amt  input  CNT_W  number of single-bit shift steps.
REQ-008 SHALL have ports d (input, WIDTH, parallel load data), si_r (input, 1, serial-in at MSB on right shift) and si_l (input, 1, serial-in at LSB on left shift).
REQ-009 SHALL have port q  output  WIDTH  register contents, driven directly from flops.
REQ-010 SHALL have ports busy (output, 1, multi-step shift in progress), done (output, 1, one-cycle completion pulse), so_r (output, 1, equal to q[0]) and so_l (output, 1, equal to q[WIDTH-1]).

Function
REQ-011 Op codes SHALL be: 0 HOLD, 1 LOAD, 2 SHR, 3 SHL, 4 ASR, 5 ROR, 6 ROL, 7 reserved (treated as HOLD).
REQ-012 FSM states SHALL be IDLE, SHIFT, DONE.
REQ-013 In IDLE, start=1 SHALL latch op and amt on that edge.
REQ-014 LOAD SHALL write q<=d on the accepting edge and go to DONE.
REQ-015 HOLD, reserved, or any shift op with amt=0 SHALL leave q unchanged and go to DONE.
REQ-016 A shift op with amt>0 SHALL go to SHIFT with cnt=amt; no step is taken on the accepting edge.
REQ-017 In SHIFT, each cycle SHALL perform exactly one step and decrement cnt; the step with cnt=1 SHALL transition to DONE.
REQ-018 SHR SHALL compute q<={si_r,q[WIDTH-1:1]} and SHL SHALL compute q<={q[WIDTH-2:0],si_l}; si_r and si_l SHALL be sampled live on each step.
REQ-019 ASR SHALL replicate q[WIDTH-1]; ROR and ROL SHALL rotate by one bit per step.
REQ-020 amt greater than WIDTH SHALL be performed literally as amt steps (no modulo reduction).
REQ-021 busy SHALL equal 1 exactly while in SHIFT.
REQ-022 done SHALL equal 1 exactly while in DONE; DONE SHALL last one cycle and then return to IDLE.
REQ-023 start outside IDLE SHALL be ignored and SHALL NOT be queued.
REQ-024 Latency from the accepting edge to done high SHALL be 1 cycle for LOAD/HOLD/amt=0 and amt+1 cycles for shifts.

Reset
REQ-025 rst=1 at a clock edge SHALL set q=0, state=IDLE, cnt=0, busy=0 and done=0, overriding start.
REQ-026 rst asserted mid-SHIFT SHALL abort the operation with no done pulse.

Configuration
REQ-027 Macro USR_ROTATE_EN defined SHALL enable ROR and ROL as specified.
REQ-028 Without USR_ROTATE_EN, op codes 5 and 6 SHALL behave as HOLD (q unchanged, done after 1 cycle) and no rotate logic SHALL be synthesised.

Structure
REQ-029 Package usr_pkg SHALL hold the op-code enum, the FSM state enum and a default-WIDTH constant.
REQ-030 Per-bit next-state muxing plus flop SHALL be a sub-module usr_bit_cell, instantiated WIDTH times; the FSM and counter SHALL remain in the top level.

Verification
REQ-031 Reset then LOAD d=0xA5 -> q=0xA5 on the accepting edge; done=1 on the next cycle only; busy never asserted.
REQ-032 q=0xA5, SHR amt=3, si_r=1 -> busy high for 3 cycles; q=0xF4; done asserted 4 cycles after acceptance.
REQ-033 q=0x81, ASR amt=2 -> q=0xE0; q=0x81, SHL amt=1, si_l=0 -> q=0x02.
REQ-034 With USR_ROTATE_EN, q=0x81, ROL amt=9 -> q=0x03; without the macro, same stimulus -> q=0x81 and done after 1 cycle.
REQ-035 start pulsed during SHIFT with op=LOAD -> ignored and q unaffected; rst asserted mid-SHIFT -> q=0x00, busy=0, no done pulse.
